// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: single-transaction engine for the parallel RTC multiplexed AD bus.
// Optional RTC_BUS_INIT_EN adds i_init_flag/i_init_data to override write data. Rev 1.0
`default_nettype none

module rtc_bus_sequencer #(
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [DATA_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
`ifdef RTC_BUS_INIT_EN
  input  logic              i_init_flag,
  input  logic [DATA_W-1:0] i_init_data,
`endif
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_cs_n,
  output logic              o_ad_sel,
  output logic              o_wr_n,
  output logic              o_rd_n,
  inout  wire  [DATA_W-1:0] io_ad
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_A_SETUP = 3'd1;
  localparam logic [2:0] c_ST_A_STRB  = 3'd2;
  localparam logic [2:0] c_ST_A_HOLD  = 3'd3;
  localparam logic [2:0] c_ST_D_SETUP = 3'd4;
  localparam logic [2:0] c_ST_D_STRB  = 3'd5;
  localparam logic [2:0] c_ST_D_HOLD  = 3'd6;
  localparam logic [2:0] c_ST_GAP     = 3'd7;

  localparam logic [7:0] c_LD_SETUP = 8'(T_SETUP);
  localparam logic [7:0] c_LD_PULSE = 8'(T_PULSE);
  localparam logic [7:0] c_LD_HOLD  = 8'(T_HOLD);
  localparam logic [7:0] c_LD_GAP   = 8'(T_GAP);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [7:0]        r_cnt;
  logic [7:0]        w_next_cnt;
  logic [7:0]        w_load_val;
  logic              w_cnt_done;
  logic              w_accept;

  logic              r_write;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_sel;
  logic [DATA_W-1:0] w_addr_cur;

  logic              w_cs_n;
  logic              w_ad_sel;
  logic              w_wr_n;
  logic              w_rd_n;
  logic              w_ad_oe;
  logic [DATA_W-1:0] w_ad_out;
  logic              w_rsp_valid;
  logic              w_req_ready;

  logic              r_ad_oe;
  logic [DATA_W-1:0] r_ad_out;
  logic [DATA_W-1:0] r_rdata;

  assign w_cnt_done = (r_cnt == 8'd1);
  assign w_accept   = (r_state == c_ST_IDLE) && i_req_valid;
  // During the accept cycle the registered address is not loaded yet.
  assign w_addr_cur = (r_state == c_ST_IDLE) ? i_req_addr : r_addr;

`ifdef RTC_BUS_INIT_EN
  assign w_wdata_sel = (i_req_write && i_init_flag) ? i_init_data : i_req_wdata;
`else
  assign w_wdata_sel = i_req_wdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:    if (i_req_valid) w_next_state = c_ST_A_SETUP;
      c_ST_A_SETUP: if (w_cnt_done)  w_next_state = c_ST_A_STRB;
      c_ST_A_STRB:  if (w_cnt_done)  w_next_state = c_ST_A_HOLD;
      c_ST_A_HOLD:  if (w_cnt_done)  w_next_state = c_ST_D_SETUP;
      c_ST_D_SETUP: if (w_cnt_done)  w_next_state = c_ST_D_STRB;
      c_ST_D_STRB:  if (w_cnt_done)  w_next_state = c_ST_D_HOLD;
      c_ST_D_HOLD:  if (w_cnt_done)  w_next_state = c_ST_GAP;
      c_ST_GAP:     if (w_cnt_done)  w_next_state = c_ST_IDLE;
      default:                       w_next_state = c_ST_IDLE;
    endcase

    w_load_val = 8'd0;
    case (w_next_state)
      c_ST_A_SETUP, c_ST_D_SETUP: w_load_val = c_LD_SETUP;
      c_ST_A_STRB,  c_ST_D_STRB:  w_load_val = c_LD_PULSE;
      c_ST_A_HOLD,  c_ST_D_HOLD:  w_load_val = c_LD_HOLD;
      c_ST_GAP:                   w_load_val = c_LD_GAP;
      default:                    w_load_val = 8'd0;
    endcase

    if (w_next_state != r_state)
      w_next_cnt = w_load_val;
    else if (r_state == c_ST_IDLE)
      w_next_cnt = r_cnt;
    else
      w_next_cnt = r_cnt - 8'd1;
  end

  // Bus outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    w_cs_n      = 1'b1;
    w_ad_sel    = 1'b0;
    w_wr_n      = 1'b1;
    w_rd_n      = 1'b1;
    w_ad_oe     = 1'b0;
    w_ad_out    = '0;
    w_rsp_valid = 1'b0;
    w_req_ready = 1'b0;
    case (w_next_state)
      c_ST_IDLE: w_req_ready = 1'b1;
      c_ST_A_SETUP, c_ST_A_STRB, c_ST_A_HOLD: begin
        w_cs_n   = 1'b0;
        w_ad_sel = 1'b1;
        w_ad_oe  = 1'b1;
        w_ad_out = w_addr_cur;
        w_wr_n   = (w_next_state != c_ST_A_STRB);
      end
      c_ST_D_SETUP, c_ST_D_STRB, c_ST_D_HOLD: begin
        w_cs_n   = 1'b0;
        w_ad_oe  = r_write;
        w_ad_out = r_write ? r_wdata : '0;
        w_wr_n   = !((w_next_state == c_ST_D_STRB) && r_write);
        w_rd_n   = !((w_next_state == c_ST_D_STRB) && !r_write);
      end
      c_ST_GAP: w_rsp_valid = (r_state != c_ST_GAP);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_cs_n      <= 1'b1;
      o_ad_sel    <= 1'b0;
      o_wr_n      <= 1'b1;
      o_rd_n      <= 1'b1;
      r_ad_oe     <= 1'b0;
      r_ad_out    <= '0;
      o_rsp_valid <= 1'b0;
      o_req_ready <= 1'b1;
    end else begin
      o_cs_n      <= w_cs_n;
      o_ad_sel    <= w_ad_sel;
      o_wr_n      <= w_wr_n;
      o_rd_n      <= w_rd_n;
      r_ad_oe     <= w_ad_oe;
      r_ad_out    <= w_ad_out;
      o_rsp_valid <= w_rsp_valid;
      o_req_ready <= w_req_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= w_wdata_sel;
      end
      // Sample on the edge closing the final read-strobe cycle.
      if ((r_state == c_ST_D_STRB) && w_cnt_done && !r_write)
        r_rdata <= io_ad;
    end
  end

  assign o_rsp_rdata = r_rdata;
  assign io_ad       = r_ad_oe ? r_ad_out : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed checks on a default-parameter and a minimum-parameter instance.
// Define RTC_BUS_INIT_EN to also exercise the init-data override. Rev 1.0
`default_nettype none

module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, w0 = 1'b0;
  logic [7:0] a0 = '0, d0 = '0, md0 = '0;
  logic       rdy0, rv0, cs0, sel0, wrn0, rdn0;
  logic [7:0] rdata0;
  wire  [7:0] ad0;

  logic       v1 = 1'b0, w1 = 1'b0;
  logic [3:0] a1 = '0, d1 = '0, md1 = '0;
  logic       rdy1, rv1, cs1, sel1, wrn1, rdn1;
  logic [3:0] rdata1;
  wire  [3:0] ad1;

`ifdef RTC_BUS_INIT_EN
  logic       if0 = 1'b0, if1 = 1'b0;
  logic [7:0] id0 = '0;
  logic [3:0] id1 = '0;
`endif

  // RTC pin model: drives read data only while rd_n is low.
  assign ad0 = !rdn0 ? md0 : 8'bz;
  assign ad1 = !rdn1 ? md1 : 4'bz;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_bus_sequencer u_dut (
    .clk(clk), .reset(reset),
    .i_req_valid(v0), .o_req_ready(rdy0), .i_req_write(w0),
    .i_req_addr(a0), .i_req_wdata(d0),
`ifdef RTC_BUS_INIT_EN
    .i_init_flag(if0), .i_init_data(id0),
`endif
    .o_rsp_valid(rv0), .o_rsp_rdata(rdata0),
    .o_cs_n(cs0), .o_ad_sel(sel0), .o_wr_n(wrn0), .o_rd_n(rdn0), .io_ad(ad0)
  );

  rtc_bus_sequencer #(
    .DATA_W(4), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)
  ) u_dut_min (
    .clk(clk), .reset(reset),
    .i_req_valid(v1), .o_req_ready(rdy1), .i_req_write(w1),
    .i_req_addr(a1), .i_req_wdata(d1),
`ifdef RTC_BUS_INIT_EN
    .i_init_flag(if1), .i_init_data(id1),
`endif
    .o_rsp_valid(rv1), .o_rsp_rdata(rdata1),
    .o_cs_n(cs1), .o_ad_sel(sel1), .o_wr_n(wrn1), .o_rd_n(rdn1), .io_ad(ad1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] zmask(input int w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < w; i++) v[i] = 1'bz;
    return v;
  endfunction

  // {cs_n, ad_sel, wr_n, rd_n, rsp_valid, req_ready} expected in cycle c after accept.
  function automatic logic [5:0] exp_ctl(input int s, input int p, input int h, input int g,
                                         input bit wr, input int c);
    int  l;
    logic cs, sel, wn, rn, rv, rdy;
    l = s + p + h;
    cs = 1; sel = 0; wn = 1; rn = 1; rv = 0; rdy = 0;
    if (c <= l) begin
      cs = 0; sel = 1;
      if (c > s && c <= s + p) wn = 0;
    end else if (c <= 2 * l) begin
      cs = 0;
      if (c > l + s && c <= l + s + p) begin
        if (wr) wn = 0; else rn = 0;
      end
    end else if (c <= 2 * l + g) begin
      rv = (c == 2 * l + 1);
    end else begin
      rdy = 1;
    end
    return {cs, sel, wn, rn, rv, rdy};
  endfunction

  function automatic logic [31:0] exp_ad(input int w, input int s, input int p, input int h,
                                         input bit wr, input logic [7:0] addr,
                                         input logic [7:0] wd, input logic [7:0] md, input int c);
    int l;
    l = s + p + h;
    if (c <= l) return {24'b0, addr};
    if (c <= 2 * l) begin
      if (wr) return {24'b0, wd};
      if (c > l + s && c <= l + s + p) return {24'b0, md};
    end
    return zmask(w);
  endfunction

  // Issues one request from an idle, negedge-aligned start and checks every cycle to req_ready.
  task automatic run_txn(input int which, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_wd,
                         input logic [7:0] md, input logic [7:0] exp_rd, input string name);
    int s, p, h, g, w, l, n;
    logic [31:0] octl, oad, ord;
    if (which == 0) begin s = 2; p = 4; h = 2; g = 3; w = 8; end
    else begin s = 1; p = 1; h = 1; g = 1; w = 4; end
    l = s + p + h;
    n = 2 * l + g + 1;
    if (which == 0) begin v0 = 1; w0 = wr; a0 = addr; d0 = wdata; md0 = md; end
    else begin v1 = 1; w1 = wr; a1 = addr[3:0]; d1 = wdata[3:0]; md1 = md[3:0]; end
    @(posedge clk);
    #1;
    v0 = 0;
    v1 = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      octl = (which == 0) ? {26'b0, cs0, sel0, wrn0, rdn0, rv0, rdy0}
                          : {26'b0, cs1, sel1, wrn1, rdn1, rv1, rdy1};
      oad  = (which == 0) ? {24'b0, ad0} : {28'b0, ad1};
      check_val($sformatf("%s_ctl_c%0d", name, c), octl, {26'b0, exp_ctl(s, p, h, g, wr, c)});
      check_val($sformatf("%s_ad_c%0d", name, c), oad, exp_ad(w, s, p, h, wr, addr, exp_wd, md, c));
      if (c == 2 * l + 1) begin
        ord = (which == 0) ? {24'b0, rdata0} : {28'b0, rdata1};
        check_val($sformatf("%s_rdata", name), ord, {24'b0, exp_rd});
      end
    end
  endtask

  int  gap_cnt;
  int  start2;
  bit  saw_rv;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_ctl0", {26'b0, cs0, sel0, wrn0, rdn0, rv0, rdy0}, 32'h2D);
    check_val("rst_ad0", {24'b0, ad0}, zmask(8));
    check_val("rst_rdata0", {24'b0, rdata0}, 32'h0);
    check_val("rst_ctl1", {26'b0, cs1, sel1, wrn1, rdn1, rv1, rdy1}, 32'h2D);
    check_val("rst_ad1", {28'b0, ad1}, zmask(4));
    check_val("rst_rdata1", {28'b0, rdata1}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(0, 1'b1, 8'h21, 8'h5A, 8'h5A, 8'h00, 8'h00, "wr1");
    run_txn(0, 1'b0, 8'h24, 8'h00, 8'h00, 8'hA7, 8'hA7, "rd1");
    run_txn(0, 1'b1, 8'h30, 8'h3C, 8'h3C, 8'h00, 8'hA7, "wr2");

    // Back-to-back writes with req_valid held high throughout.
    v0 = 1; w0 = 1; a0 = 8'h40; d0 = 8'h01;
    @(posedge clk);
    #1;
    a0 = 8'h41; d0 = 8'h02;
    gap_cnt = 0;
    start2  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= 20 && cs0 === 1'b1 && rdy0 === 1'b0) gap_cnt++;
      if (start2 == 0 && c > 17 && cs0 === 1'b0) start2 = c;
      if (c == 9)  check_val("b2b_wdata1", {24'b0, ad0}, 32'h01);
      if (c == 19) check_val("b2b_ready_c19", {31'b0, rdy0}, 32'h0);
      if (c == 20) check_val("b2b_ready_c20", {31'b0, rdy0}, 32'h1);
      if (c == 21) begin
        check_val("b2b_addr2", {24'b0, ad0}, 32'h41);
        v0 = 0;
      end
      if (c == 29) check_val("b2b_wdata2", {24'b0, ad0}, 32'h02);
      if (c == 37) check_val("b2b_rsp2", {31'b0, rv0}, 32'h1);
      if (c == 40) check_val("b2b_ready_c40", {31'b0, rdy0}, 32'h1);
    end
    check_val("b2b_gap_cycles", gap_cnt, 32'd3);
    check_val("b2b_second_start", start2, 32'd21);

    // Asynchronous reset during the data strobe of a write.
    v0 = 1; w0 = 1; a0 = 8'h33; d0 = 8'hC3;
    @(posedge clk);
    #1;
    v0 = 0;
    repeat (12) @(negedge clk);
    check_val("rst_mid_pre_wr_n", {31'b0, wrn0}, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_mid_ctl", {26'b0, cs0, sel0, wrn0, rdn0, rv0, rdy0}, 32'h2D);
    check_val("rst_mid_ad", {24'b0, ad0}, zmask(8));
    saw_rv = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rv0 !== 1'b0) saw_rv = 1;
    end
    check_val("rst_mid_no_rsp", {31'b0, saw_rv}, 32'h0);
    run_txn(0, 1'b1, 8'h35, 8'h6B, 8'h6B, 8'h00, 8'h00, "wr_after_rst");

    run_txn(1, 1'b0, 8'h05, 8'h00, 8'h00, 8'h09, 8'h09, "min_rd");
    run_txn(1, 1'b1, 8'h0A, 8'h06, 8'h06, 8'h00, 8'h09, "min_wr");

`ifdef RTC_BUS_INIT_EN
    if0 = 1; id0 = 8'h80;
    run_txn(0, 1'b1, 8'h50, 8'h11, 8'h80, 8'h00, 8'h00, "init_on");
    if0 = 0;
    run_txn(0, 1'b1, 8'h51, 8'h11, 8'h11, 8'h00, 8'h00, "init_off");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
